grid_mover: RTL and testbench
=============================

GRID_MOVER -- requirements
Module: grid_mover

Interface
REQ-001 Parameters (name, default, meaning): X_W 10 x width; Y_W 10 y width; X_MAX 639 max x; Y_MAX 479 max y; X_INIT 320 reset x; Y_INIT 240 reset y; STEP 1 pixels per step; SPEED_DIV 4 clocks per step tick, min 1; WRAP_X 1 horizontal tunnel wrap enable; WIN_SCORE 16'd100 score threshold.
REQ-002 Port list, one per line: name direction width meaning.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ack  in  1  acknowledges WIN/LOSE and returns to INI.
REQ-006 btn  in  4  {up,down,left,right} direction request, level.
REQ-007 score  in  16  current game score.
REQ-008 hit_ghost  in  1  collision flag, level.
REQ-009 wall_req / wall_x / wall_y  out  1 / X_W / Y_W  maze lookup request and candidate coordinates.
REQ-010 wall_vld / wall_hit  in  1 / 1  lookup response strobe and wall result.
REQ-011 pos_x / pos_y  out  X_W / Y_W  registered sprite position.
REQ-012 dir  out  2  current direction (0 up, 1 down, 2 left, 3 right); moving  out  1  current direction valid.
REQ-013 step  out  1  one-cycle pulse on each position update; win / lose  out  1  terminal-state flags.

Function
REQ-014 States shall be INI, STILL, MOVING, Q_PEND, Q_CUR, WIN, LOSE, one-hot.
REQ-015 INI shall load pos to (X_INIT,Y_INIT), clear moving and pending, and go to STILL next cycle.
REQ-016 Buttons shall be latched every cycle into a pending direction with priority up>down>left>right; pending is held until consumed or reset; btn==0 leaves pending unchanged.
REQ-017 Step timer shall count 0..SPEED_DIV-1 in STILL/MOVING only, emitting a tick on wrap; it shall hold at 0 in all other states.
REQ-018 On tick: if pending valid, go to Q_PEND; else if moving, go to Q_CUR; else remain STILL.
REQ-019 Candidate = pos + STEP in the chosen direction; x below 0 or above X_MAX wraps to the opposite edge when WRAP_X=1, otherwise the move is blocked without a query; y out of range is always blocked without a query.
REQ-020 In Q_PEND/Q_CUR wall_req shall be high with the candidate stable until the cycle wall_vld=1; wall_req shall drop the following cycle.
REQ-021 Q_PEND response: no wall -> pos<=candidate, dir<=pending, moving<=1, pending cleared, step pulse, go to MOVING; wall -> go to Q_CUR if moving, else STILL, pending retained.
REQ-022 Q_CUR response: no wall -> pos<=candidate, step pulse, go to MOVING; wall -> moving<=0, go to STILL.
REQ-023 Ticks during Q_PEND/Q_CUR shall not occur (timer held); wall_vld outside query states shall be ignored.
REQ-024 In any state except INI/WIN/LOSE, hit_ghost=1 shall go to LOSE next cycle, else score>=WIN_SCORE shall go to WIN; both true -> LOSE; this overrides any pending response, and pos is not updated.
REQ-025 WIN/LOSE shall freeze pos, hold win/lose high, keep wall_req low, and go to INI on ack=1.

Reset
REQ-026 On reset: state INI, pos (X_INIT,Y_INIT), dir 0, moving 0, pending cleared, timer 0, wall_req 0, step 0, win 0, lose 0.
REQ-027 Reset during a query shall drop wall_req next cycle; a later wall_vld shall have no effect.

Structure
REQ-028 Package grid_mover_pkg shall hold state one-hot constants and direction encodings, shared with the maze and render blocks.
REQ-029 Step timer shall be a sub-module step_timer (parameter SPEED_DIV; ports clk, reset, en, tick).

Verification
REQ-030 Reset, btn=right, wall_hit=0 with one-cycle responses -> first step to (321,240) within SPEED_DIV+3 cycles, then +1 x per tick, dir=3, moving=1.
REQ-031 Moving right, btn=up with wall above -> Q_PEND hit, Q_CUR clear, pos x+1; after the wall clears, up taken, dir=0.
REQ-032 pos_x=639 moving right, WRAP_X=1 -> pos_x=0; with WRAP_X=0 -> no wall_req, moving=0, state STILL.
REQ-033 wall_vld delayed 5 cycles -> wall_req and wall_x/wall_y stable all 5 cycles, single step pulse.
REQ-034 score=100 and hit_ghost=1 in the same cycle during Q_CUR -> LOSE, win=0, pos unchanged; ack -> INI then STILL at (320,240).
REQ-035 reset asserted while wall_req=1, wall_vld pulsed 2 cycles later -> pos stays (320,240), no step pulse.

Source files
------------

// File: rtl/grid_mover_pkg.sv
// Shared encodings for the grid mover and the blocks around it (maze, render):
// one-hot controller states, direction codes and the button priority decode.
package grid_mover_pkg;

  localparam logic [6:0] ST_INI    = 7'b0000001;
  localparam logic [6:0] ST_STILL  = 7'b0000010;
  localparam logic [6:0] ST_MOVING = 7'b0000100;
  localparam logic [6:0] ST_Q_PEND = 7'b0001000;
  localparam logic [6:0] ST_Q_CUR  = 7'b0010000;
  localparam logic [6:0] ST_WIN    = 7'b0100000;
  localparam logic [6:0] ST_LOSE   = 7'b1000000;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Bit positions inside the {up,down,left,right} button vector
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Highest-priority pressed button; caller guarantees at least one bit set
  function automatic logic [1:0] btn_to_dir(input logic [3:0] b);
    if (b[BTN_UP])        return DIR_UP;
    else if (b[BTN_DOWN]) return DIR_DOWN;
    else if (b[BTN_LEFT]) return DIR_LEFT;
    else                  return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/grid_mover_step_timer.sv
// Movement pacing: counts 0..SPEED_DIV-1 while enabled and flags the wrap
// cycle as a tick. Disabling it parks the count at zero.
module step_timer #(
  parameter int SPEED_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPEED_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, held at zero whenever movement is not being paced
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/grid_mover.sv
// Sprite movement controller: latches the requested direction, paces moves
// with a step timer, asks the maze whether the next cell is free and updates
// the registered position. Ghost collision / score threshold end the round.
module grid_mover
  import grid_mover_pkg::*;
#(
  parameter int          X_W       = 10,
  parameter int          Y_W       = 10,
  parameter int          X_MAX     = 639,
  parameter int          Y_MAX     = 479,
  parameter int          X_INIT    = 320,
  parameter int          Y_INIT    = 240,
  parameter int          STEP      = 1,
  parameter int          SPEED_DIV = 4,
  parameter int          WRAP_X    = 1,
  parameter logic [15:0] WIN_SCORE = 16'd100
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ack,
  input  logic [3:0]     btn,
  input  logic [15:0]    score,
  input  logic           hit_ghost,
  output logic           wall_req,
  output logic [X_W-1:0] wall_x,
  output logic [Y_W-1:0] wall_y,
  input  logic           wall_vld,
  input  logic           wall_hit,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     dir,
  output logic           moving,
  output logic           step,
  output logic           win,
  output logic           lose
);

  typedef struct packed {
    logic           ok;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cand_t;

  logic [6:0] st;
  logic       pend_vld;
  logic [1:0] pend_dir;
  logic [1:0] q_dir;
  logic       timer_en;
  logic       tick;
  cand_t      c_pend;
  cand_t      c_cur;

  // Next cell one STEP away; x may tunnel across the screen, y never does.
  // ok=0 means the move is blocked without consulting the maze.
  function automatic cand_t calc_cand(input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y,
                                      input logic [1:0]     d);
    cand_t c;
    int    nx;
    int    ny;
    nx   = int'(x);
    ny   = int'(y);
    c.ok = 1'b1;
    case (d)
      DIR_UP:   ny = ny - STEP;
      DIR_DOWN: ny = ny + STEP;
      DIR_LEFT: nx = nx - STEP;
      default:  nx = nx + STEP;
    endcase
    if (ny < 0 || ny > Y_MAX) c.ok = 1'b0;
    if (nx < 0) begin
      if (WRAP_X != 0) nx = nx + X_MAX + 1;
      else             c.ok = 1'b0;
    end else if (nx > X_MAX) begin
      if (WRAP_X != 0) nx = nx - X_MAX - 1;
      else             c.ok = 1'b0;
    end
    c.x = X_W'(nx);
    c.y = Y_W'(ny);
    return c;
  endfunction

  assign c_pend   = calc_cand(pos_x, pos_y, pend_dir);
  assign c_cur    = calc_cand(pos_x, pos_y, dir);
  assign timer_en = (st == ST_STILL) || (st == ST_MOVING);
  assign win      = (st == ST_WIN);
  assign lose     = (st == ST_LOSE);

  step_timer #(.SPEED_DIV(SPEED_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (timer_en),
    .tick  (tick)
  );

  // Controller: pending-direction latch, maze query handshake and position update
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= ST_INI;
      pos_x    <= X_W'(X_INIT);
      pos_y    <= Y_W'(Y_INIT);
      dir      <= DIR_UP;
      moving   <= 1'b0;
      pend_vld <= 1'b0;
      pend_dir <= DIR_UP;
      q_dir    <= DIR_UP;
      wall_req <= 1'b0;
      wall_x   <= X_W'(X_INIT);
      wall_y   <= Y_W'(Y_INIT);
      step     <= 1'b0;
    end else begin
      step <= 1'b0;
      // A fresh press always refreshes the pending request, even in the
      // cycle the previous one is consumed.
      if (btn != 4'd0) begin
        pend_vld <= 1'b1;
        pend_dir <= btn_to_dir(btn);
      end
      case (st)
        ST_INI: begin
          pos_x    <= X_W'(X_INIT);
          pos_y    <= Y_W'(Y_INIT);
          moving   <= 1'b0;
          pend_vld <= 1'b0;
          st       <= ST_STILL;
        end
        ST_STILL, ST_MOVING: begin
          if (hit_ghost) begin
            st <= ST_LOSE;
          end else if (score >= WIN_SCORE) begin
            st <= ST_WIN;
          end else if (tick) begin
            if (pend_vld && c_pend.ok) begin
              st       <= ST_Q_PEND;
              wall_req <= 1'b1;
              wall_x   <= c_pend.x;
              wall_y   <= c_pend.y;
              q_dir    <= pend_dir;
            end else if (moving && c_cur.ok) begin
              st       <= ST_Q_CUR;
              wall_req <= 1'b1;
              wall_x   <= c_cur.x;
              wall_y   <= c_cur.y;
            end else if (moving) begin
              moving <= 1'b0;
              st     <= ST_STILL;
            end
          end
        end
        ST_Q_PEND: begin
          if (hit_ghost) begin
            st       <= ST_LOSE;
            wall_req <= 1'b0;
          end else if (score >= WIN_SCORE) begin
            st       <= ST_WIN;
            wall_req <= 1'b0;
          end else if (wall_req && wall_vld) begin
            wall_req <= 1'b0;
            if (!wall_hit) begin
              pos_x    <= wall_x;
              pos_y    <= wall_y;
              dir      <= q_dir;
              moving   <= 1'b1;
              pend_vld <= |btn;
              step     <= 1'b1;
              st       <= ST_MOVING;
            end else if (moving && c_cur.ok) begin
              // Turn refused: keep going straight. The request line is
              // re-raised one cycle later by Q_CUR.
              st     <= ST_Q_CUR;
              wall_x <= c_cur.x;
              wall_y <= c_cur.y;
            end else begin
              moving <= 1'b0;
              st     <= ST_STILL;
            end
          end
        end
        ST_Q_CUR: begin
          if (hit_ghost) begin
            st       <= ST_LOSE;
            wall_req <= 1'b0;
          end else if (score >= WIN_SCORE) begin
            st       <= ST_WIN;
            wall_req <= 1'b0;
          end else if (!wall_req) begin
            wall_req <= 1'b1;
          end else if (wall_vld) begin
            wall_req <= 1'b0;
            if (!wall_hit) begin
              pos_x <= wall_x;
              pos_y <= wall_y;
              step  <= 1'b1;
              st    <= ST_MOVING;
            end else begin
              moving <= 1'b0;
              st     <= ST_STILL;
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          if (ack) st <= ST_INI;
        end
        default: st <= ST_INI;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_mover.sv
// Bench for grid_mover: two instances (tunnel wrap on / off) share player
// inputs; each has its own maze responder. Outputs are compared every cycle
// against a behavioural model of the movement rules.
module tb_grid_mover;

  localparam int SD = 4;
  localparam int S_INI = 0, S_STILL = 1, S_MOVING = 2, S_QP = 3, S_QC = 4, S_WIN = 5, S_LOSE = 6;

  typedef struct {
    int st;
    int x, y, d;
    bit mov, pv;
    int pd, cnt;
    bit req;
    int cx, cy, qd;
    bit stp;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset, ack, hit_ghost;
  logic [3:0]  btn;
  logic [15:0] score;
  logic        wvld[2], whit[2], wreq[2];
  logic [9:0]  wx[2], wy[2], px[2], py[2];
  logic [1:0]  dr[2];
  logic        mv[2], stp[2], wn[2], ls[2];

  int   total = 0;
  int   bad = 0;
  mdl_t m[2];
  int   wcnt[2], dly[2];
  int   dly_lo, dly_hi, wall_pct, spur_pct;
  bit   force_vld, block_up;
  bit   found, wrapped, old_req;
  int   prevx, savex, savey;

  always #5 clk = ~clk;

  grid_mover #(.WRAP_X(1)) u0 (
    .clk(clk), .reset(reset), .ack(ack), .btn(btn), .score(score), .hit_ghost(hit_ghost),
    .wall_req(wreq[0]), .wall_x(wx[0]), .wall_y(wy[0]), .wall_vld(wvld[0]), .wall_hit(whit[0]),
    .pos_x(px[0]), .pos_y(py[0]), .dir(dr[0]), .moving(mv[0]), .step(stp[0]),
    .win(wn[0]), .lose(ls[0]));

  grid_mover #(.WRAP_X(0)) u1 (
    .clk(clk), .reset(reset), .ack(ack), .btn(btn), .score(score), .hit_ghost(hit_ghost),
    .wall_req(wreq[1]), .wall_x(wx[1]), .wall_y(wy[1]), .wall_vld(wvld[1]), .wall_hit(whit[1]),
    .pos_x(px[1]), .pos_y(py[1]), .dir(dr[1]), .moving(mv[1]), .step(stp[1]),
    .win(wn[1]), .lose(ls[1]));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = S_INI; r.x = 320; r.y = 240; r.d = 0; r.mov = 0; r.pv = 0; r.pd = 0;
    r.cnt = 0; r.req = 0; r.cx = 320; r.cy = 240; r.qd = 0; r.stp = 0;
    return r;
  endfunction

  // One step away on a 640x480 field; returns 0 when the move is blocked
  function automatic bit mcand(input int x, input int y, input int d, input bit wrap,
                               output int cx, output int cy);
    cx = x; cy = y;
    case (d)
      0:       cy = y - 1;
      1:       cy = y + 1;
      2:       cx = x - 1;
      default: cx = x + 1;
    endcase
    if (cy < 0 || cy > 479) return 0;
    if (cx < 0 || cx > 639) begin
      if (!wrap) return 0;
      cx = (cx + 640) % 640;
    end
    return 1;
  endfunction

  function automatic mdl_t mstep(input mdl_t m0, input bit rst, input logic [3:0] b,
                                 input int sc, input bit gh, input bit ak,
                                 input bit vld, input bit hit, input bit wrap);
    mdl_t n;
    bit   tick, ok, taken;
    int   cx, cy;
    if (rst) return mreset();
    n = m0;
    n.stp = 0;
    tick = (m0.st == S_STILL || m0.st == S_MOVING) && (m0.cnt == SD - 1);
    n.cnt = (m0.st == S_STILL || m0.st == S_MOVING) ? (m0.cnt + 1) % SD : 0;
    if (b != 0) begin
      n.pv = 1;
      n.pd = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
    end
    case (m0.st)
      S_INI: begin
        n.x = 320; n.y = 240; n.mov = 0; n.pv = 0; n.st = S_STILL;
      end
      S_WIN, S_LOSE: if (ak) n.st = S_INI;
      default: begin
        if (gh) begin
          n.st = S_LOSE; n.req = 0;
        end else if (sc >= 100) begin
          n.st = S_WIN; n.req = 0;
        end else if (m0.st == S_STILL || m0.st == S_MOVING) begin
          if (tick) begin
            taken = 0;
            if (m0.pv) begin
              ok = mcand(m0.x, m0.y, m0.pd, wrap, cx, cy);
              if (ok) begin
                n.st = S_QP; n.req = 1; n.cx = cx; n.cy = cy; n.qd = m0.pd; taken = 1;
              end
            end
            if (!taken && m0.mov) begin
              ok = mcand(m0.x, m0.y, m0.d, wrap, cx, cy);
              if (ok) begin
                n.st = S_QC; n.req = 1; n.cx = cx; n.cy = cy;
              end else begin
                n.mov = 0; n.st = S_STILL;
              end
            end
          end
        end else if (m0.st == S_QC && !m0.req) begin
          n.req = 1;
        end else if (m0.req && vld) begin
          n.req = 0;
          if (!hit) begin
            n.x = m0.cx; n.y = m0.cy; n.mov = 1; n.stp = 1; n.st = S_MOVING;
            if (m0.st == S_QP) begin
              n.d = m0.qd; n.pv = (b != 0);
            end
          end else if (m0.st == S_QC || !m0.mov) begin
            n.mov = 0; n.st = S_STILL;
          end else begin
            ok = mcand(m0.x, m0.y, m0.d, wrap, cx, cy);
            if (ok) begin
              n.st = S_QC; n.cx = cx; n.cy = cy;
            end else begin
              n.mov = 0; n.st = S_STILL;
            end
          end
        end
      end
    endcase
    return n;
  endfunction

  task automatic set_dly(input int lo, input int hi);
    dly_lo = lo; dly_hi = hi;
    for (int i = 0; i < 2; i++) dly[i] = $urandom_range(hi, lo);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_pos_x", i), px[i], m[i].x);
      check($sformatf("u%0d_pos_y", i), py[i], m[i].y);
      check($sformatf("u%0d_dir", i), dr[i], m[i].d);
      check($sformatf("u%0d_moving", i), mv[i], m[i].mov);
      check($sformatf("u%0d_step", i), stp[i], m[i].stp);
      check($sformatf("u%0d_win", i), wn[i], m[i].st == S_WIN);
      check($sformatf("u%0d_lose", i), ls[i], m[i].st == S_LOSE);
      check($sformatf("u%0d_wall_req", i), wreq[i], m[i].req);
      if (m[i].req) begin
        check($sformatf("u%0d_wall_x", i), wx[i], m[i].cx);
        check($sformatf("u%0d_wall_y", i), wy[i], m[i].cy);
      end
    end
  endtask

  // One clock: drive maze responses, compare on the falling edge, advance the model
  task automatic cyc();
    for (int i = 0; i < 2; i++) begin
      if (force_vld)     wvld[i] = 1'b1;
      else if (m[i].req) wvld[i] = (wcnt[i] >= dly[i]);
      else               wvld[i] = ($urandom_range(99, 0) < spur_pct);
      if (block_up && m[i].req && m[i].cy < m[i].y) whit[i] = 1'b1;
      else whit[i] = ($urandom_range(99, 0) < wall_pct);
    end
    @(negedge clk);
    compare_all();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      old_req = m[i].req;
      m[i] = mstep(m[i], reset, btn, int'(score), hit_ghost, ack, wvld[i], whit[i], i == 0);
      if (reset) begin
        wcnt[i] = 0;
      end else if (old_req) begin
        if (wvld[i]) begin
          wcnt[i] = 0;
          dly[i] = $urandom_range(dly_hi, dly_lo);
        end else begin
          wcnt[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn = 4'd0; hit_ghost = 1'b0; score = 16'd0; ack = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn = 4'd0; score = 16'd0; hit_ghost = 1'b0; ack = 1'b0;
    force_vld = 0; block_up = 0; wall_pct = 0; spur_pct = 0;
    for (int i = 0; i < 2; i++) begin
      wvld[i] = 1'b0; whit[i] = 1'b0; wcnt[i] = 0; m[i] = mreset();
    end
    set_dly(0, 0);
    @(posedge clk);
    #1;
    repeat (2) cyc();

    // Straight run to the right edge: wrap on u0, blocked on u1
    reset = 1'b0;
    btn = 4'b0001;
    found = 0;
    for (int k = 0; k < SD + 3 && !found; k++) begin
      cyc();
      if (px[0] == 10'd321) found = 1;
    end
    check("first_step_in_budget", found, 1);
    wrapped = 0;
    for (int k = 0; k < 1700; k++) begin
      prevx = px[0];
      cyc();
      if (prevx == 639 && px[0] == 10'd0) wrapped = 1;
    end
    check("u0_tunnel_wrap", wrapped, 1);
    check("u0_dir_right", dr[0], 3);
    check("u1_edge_x", px[1], 639);
    check("u1_edge_stopped", mv[1], 0);

    // Turn request refused by a wall above, taken once the wall clears
    do_reset();
    btn = 4'b0001;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc();
      if (mv[0]) found = 1;
    end
    check("r031_moving", found, 1);
    btn = 4'b1000; block_up = 1;
    cyc();
    btn = 4'd0;
    repeat (15) cyc();
    check("r031_dir_kept", dr[0], 3);
    block_up = 0;
    repeat (15) cyc();
    check("r031_up_taken", dr[0], 0);

    // Slow maze responses: request and candidate must hold steady
    set_dly(5, 5);
    btn = 4'b0001;
    repeat (40) cyc();
    btn = 4'd0;

    // Ghost and winning score together during a straight-ahead query
    do_reset();
    set_dly(0, 0);
    btn = 4'b0001;
    repeat (8) cyc();
    btn = 4'd0;
    repeat (8) cyc();
    set_dly(30, 30);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (m[0].st == S_QC && m[0].req) found = 1;
    end
    check("r034_in_query", found, 1);
    savex = px[0]; savey = py[0];
    score = 16'd100; hit_ghost = 1'b1;
    cyc();
    score = 16'd0; hit_ghost = 1'b0;
    cyc();
    check("r034_lose", ls[0], 1);
    check("r034_no_win", wn[0], 0);
    check("r034_pos_frozen", px[0], savex);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    cyc();
    check("r034_restart_x", px[0], 320);
    check("r034_restart_y", py[0], 240);

    // Reset in the middle of a query, stray response afterwards
    set_dly(30, 30);
    btn = 4'b0001;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc();
      if (m[0].req) found = 1;
    end
    check("r035_in_query", found, 1);
    do_reset();
    cyc();
    force_vld = 1;
    cyc();
    force_vld = 0;
    repeat (3) cyc();
    check("r035_pos_x", px[0], 320);
    check("r035_no_step", stp[0], 0);

    // Random play
    set_dly(0, 5);
    wall_pct = 35; spur_pct = 12;
    for (int k = 0; k < 6000; k++) begin
      btn = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'd0;
      hit_ghost = ($urandom_range(299, 0) == 0);
      score = ($urandom_range(199, 0) == 0) ? 16'(100 + $urandom_range(50, 0))
                                            : 16'($urandom_range(99, 0));
      ack = ($urandom_range(7, 0) == 0);
      reset = ($urandom_range(799, 0) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
